cascaded_digit_counter: RTL and testbench

Parametrised multi-digit up/down counter and successor to the single-digit event counter. It has DIGITS digits of radix RADIX each, with digit-to-digit carry and borrow propagation inside one cycle. It adds selectable wrap, saturate, limit and hold modes, a synchronous load, and carry-in/carry-out for chaining instances. It sits between the event-pulse front end and the display/segment drivers.

---
 rtl/cascaded_digit_counter.sv | 124 ++++++++++++
 tb/tb_cascaded_digit_counter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cascaded_digit_counter.sv
// ============================================================================
// cascaded_digit_counter
//   Multi-digit radix-N up/down counter with wrap/saturate/limit/hold modes,
//   synchronous load and chainable carry.                 Revision: 1.0
// ============================================================================
`default_nettype none

module cascaded_digit_counter #(
  parameter int DIGITS  = 2,
  parameter int DIGIT_W = 4,
  parameter int RADIX   = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inc,
  input  logic                      carry_in,
  input  logic                      up_down_sel,
  input  logic [1:0]                mode,
  input  logic [DIGITS*DIGIT_W-1:0] limit,
  input  logic                      load,
  input  logic [DIGITS*DIGIT_W-1:0] load_val,
  output logic [DIGITS*DIGIT_W-1:0] cnt_out,
  output logic                      carry_out,
  output logic                      at_limit
);

  localparam int               W           = DIGITS * DIGIT_W;
  localparam logic [DIGIT_W-1:0] C_DMAX    = DIGIT_W'(RADIX - 1);
  localparam logic [DIGIT_W-1:0] C_ONE     = DIGIT_W'(1);
  localparam logic [1:0]       C_MODE_WRAP = 2'b00;
  localparam logic [1:0]       C_MODE_LIM  = 2'b10;
  localparam logic [1:0]       C_MODE_HOLD = 2'b11;

  logic [W-1:0] r_cnt;
  logic         r_carry;
  logic [W-1:0] w_lim_c;
  logic [W-1:0] w_load_c;
  logic [W-1:0] w_all_max;
  logic [W-1:0] w_top;
  logic [W-1:0] w_cnt_inc;
  logic [W-1:0] w_cnt_dec;
  logic         w_inc_cy;
  logic         w_dec_bw;
  logic         w_step;
  logic         w_at_limit;

  // Out-of-range digits saturate to RADIX-1 so stored digits stay legal.
  for (genvar d = 0; d < DIGITS; d++) begin : g_clamp
    assign w_lim_c[d*DIGIT_W +: DIGIT_W]  = (limit[d*DIGIT_W +: DIGIT_W] > C_DMAX) ?
                                            C_DMAX : limit[d*DIGIT_W +: DIGIT_W];
    assign w_load_c[d*DIGIT_W +: DIGIT_W] = (load_val[d*DIGIT_W +: DIGIT_W] > C_DMAX) ?
                                            C_DMAX : load_val[d*DIGIT_W +: DIGIT_W];
    assign w_all_max[d*DIGIT_W +: DIGIT_W] = C_DMAX;
  end

  assign w_top      = (mode == C_MODE_LIM) ? w_lim_c : w_all_max;
  assign w_step     = inc | carry_in;
  assign w_at_limit = up_down_sel ? (r_cnt == '0) : (r_cnt == w_top);

  always_comb begin
    w_cnt_inc = r_cnt;
    w_inc_cy  = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_inc_cy) begin
        if (r_cnt[d*DIGIT_W +: DIGIT_W] == C_DMAX) begin
          w_cnt_inc[d*DIGIT_W +: DIGIT_W] = '0;
        end else begin
          w_cnt_inc[d*DIGIT_W +: DIGIT_W] = r_cnt[d*DIGIT_W +: DIGIT_W] + C_ONE;
          w_inc_cy = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_cnt_dec = r_cnt;
    w_dec_bw  = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_dec_bw) begin
        if (r_cnt[d*DIGIT_W +: DIGIT_W] == '0) begin
          w_cnt_dec[d*DIGIT_W +: DIGIT_W] = C_DMAX;
        end else begin
          w_cnt_dec[d*DIGIT_W +: DIGIT_W] = r_cnt[d*DIGIT_W +: DIGIT_W] - C_ONE;
          w_dec_bw = 1'b0;
        end
      end
    end
  end

  // Wrapping at TOP/0 in wrap mode falls out of the digit chains directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
    end else if (load) begin
      r_cnt   <= ((mode == C_MODE_LIM) && (w_load_c > w_lim_c)) ? w_lim_c : w_load_c;
      r_carry <= 1'b0;
    end else if ((mode == C_MODE_LIM) && (r_cnt > w_lim_c)) begin
      r_cnt   <= w_lim_c;
      r_carry <= 1'b0;
    end else if (w_step && (mode != C_MODE_HOLD)) begin
      if (w_at_limit) begin
        if (mode == C_MODE_WRAP) begin
          r_cnt   <= up_down_sel ? w_cnt_dec : w_cnt_inc;
          r_carry <= 1'b1;
        end else begin
          r_carry <= 1'b0;
        end
      end else begin
        r_cnt   <= up_down_sel ? w_cnt_dec : w_cnt_inc;
        r_carry <= 1'b0;
      end
    end else begin
      r_carry <= 1'b0;
    end
  end

  assign cnt_out   = r_cnt;
  assign carry_out = r_carry;
  assign at_limit  = w_at_limit;

endmodule

`default_nettype wire

// File: tb/tb_cascaded_digit_counter.sv
// ============================================================================
// tb_cascaded_digit_counter
//   Scoreboard bench against an integer-valued model, DIGITS=2, RADIX=10.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cascaded_digit_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       inc = 1'b0, carry_in = 1'b0, up_down_sel = 1'b0, load = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] limit = 8'h00, load_val = 8'h00;
  logic [7:0] cnt_out;
  logic       carry_out, at_limit;

  always #5 clk = ~clk;

  cascaded_digit_counter #(.DIGITS(2), .DIGIT_W(4), .RADIX(10)) dut (
    .clk(clk), .reset(reset), .inc(inc), .carry_in(carry_in),
    .up_down_sel(up_down_sel), .mode(mode), .limit(limit), .load(load),
    .load_val(load_val), .cnt_out(cnt_out), .carry_out(carry_out),
    .at_limit(at_limit)
  );

  typedef struct packed {
    logic [7:0] cnt;
    logic       co;
    logic       al;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   m_val  = 0;
  logic m_co   = 1'b0;

  function automatic int clampv(input logic [7:0] v);
    int d0, d1;
    d0 = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
    d1 = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
    return d1 * 10 + d0;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Reference: counter value held as a plain integer 0..99.
  task automatic model_step();
    int lim, top, lv;
    lim = clampv(limit);
    top = (mode == 2'b10) ? lim : 99;
    m_co = 1'b0;
    if (!reset) begin
      m_val = 0;
    end else if (load) begin
      lv    = clampv(load_val);
      m_val = (mode == 2'b10 && lv > lim) ? lim : lv;
    end else if (mode == 2'b10 && m_val > lim) begin
      m_val = lim;
    end else if ((inc || carry_in) && mode != 2'b11) begin
      if (!up_down_sel) begin
        if (m_val == top) begin
          if (mode == 2'b00) begin m_val = 0; m_co = 1'b1; end
        end else m_val = m_val + 1;
      end else begin
        if (m_val == 0) begin
          if (mode == 2'b00) begin m_val = 99; m_co = 1'b1; end
        end else m_val = m_val - 1;
      end
    end
    q.push_back('{cnt: to_bcd(m_val), co: m_co,
                  al: up_down_sel ? (m_val == 0) : (m_val == top)});
  endtask

  task automatic drive(input logic rv, input logic iv, input logic cv,
                       input logic dv, input logic [1:0] mv, input logic [7:0] lim,
                       input logic ld, input logic [7:0] lval);
    @(negedge clk);
    reset = rv; inc = iv; carry_in = cv; up_down_sel = dv; mode = mv;
    limit = lim; load = ld; load_val = lval;
    model_step();
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (cnt_out !== 8'h00 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: cnt_out=%h carry_out=%b required cnt_out=00 carry_out=0",
               cnt_out, carry_out);
    end
    model_step();
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (cnt_out !== e.cnt || carry_out !== e.co || at_limit !== e.al) begin
        errors++;
        $display("FAIL edge_check t=%0t: cnt_out=%h carry_out=%b at_limit=%b required %h %b %b",
                 $time, cnt_out, carry_out, at_limit, e.cnt, e.co, e.al);
      end
    end
  end

  initial begin
    #1;
    checks++;
    if (cnt_out !== 8'h00 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: cnt_out=%h carry_out=%b required 00 0", cnt_out, carry_out);
    end

    repeat (3) drive(0, 1, 0, 0, 2'b00, 8'h00, 0, 8'h00);
    repeat (12) drive(1, 1, 0, 0, 2'b00, 8'h00, 0, 8'h00);

    drive(1, 0, 0, 0, 2'b00, 8'h00, 1, 8'h99);
    drive(1, 1, 0, 0, 2'b00, 8'h00, 0, 8'h00);
    drive(1, 0, 0, 0, 2'b00, 8'h00, 0, 8'h00);
    drive(1, 1, 0, 1, 2'b00, 8'h00, 0, 8'h00);
    drive(1, 1, 0, 1, 2'b00, 8'h00, 0, 8'h00);
    drive(1, 0, 0, 1, 2'b00, 8'h00, 0, 8'h00);

    drive(1, 0, 0, 0, 2'b01, 8'h00, 1, 8'h99);
    repeat (5) drive(1, 1, 0, 0, 2'b01, 8'h00, 0, 8'h00);
    drive(1, 0, 0, 1, 2'b01, 8'h00, 1, 8'h00);
    repeat (3) drive(1, 1, 0, 1, 2'b01, 8'h00, 0, 8'h00);
    drive(1, 0, 0, 0, 2'b11, 8'h00, 1, 8'h42);
    repeat (4) drive(1, 1, 0, 0, 2'b11, 8'h00, 0, 8'h00);

    drive(1, 0, 0, 0, 2'b10, 8'h25, 1, 8'h20);
    repeat (8) drive(1, 1, 0, 0, 2'b10, 8'h25, 0, 8'h00);
    drive(1, 0, 0, 0, 2'b10, 8'h17, 0, 8'h00);
    drive(1, 0, 0, 0, 2'b10, 8'h17, 1, 8'h30);

    drive(1, 0, 0, 0, 2'b00, 8'h00, 1, 8'h40);
    drive(1, 1, 1, 0, 2'b00, 8'h00, 0, 8'h00);
    drive(1, 1, 0, 0, 2'b00, 8'h00, 1, 8'h55);
    drive(1, 0, 0, 0, 2'b00, 8'h00, 1, 8'hAF);

    drive(1, 0, 0, 0, 2'b00, 8'h00, 1, 8'h30);
    repeat (7) drive(1, 1, 0, 0, 2'b00, 8'h00, 0, 8'h00);
    async_reset_check();
    repeat (5) drive(1, 1, 0, 0, 2'b00, 8'h00, 0, 8'h00);

    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 63) != 0), $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0 ? ~up_down_sel : up_down_sel,
            $urandom_range(0, 15) == 0 ? 2'($urandom) : mode,
            $urandom_range(0, 15) == 0 ? 8'($urandom) : limit,
            $urandom_range(0, 15) == 0, 8'($urandom));
    end

    drive(1, 0, 0, 0, 2'b00, 8'h00, 0, 8'h00);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: queue_left=%0d required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
